// File: rtl/mmul_parallel_engine_seq.sv
// mmul_parallel_engine_seq
// Job-sequencing engine that sits between the HWPE streamer and the kernel wrapper.
// It gates each stream handshake and launches a programmed number of back-to-back
// kernel jobs. Each channel is held to a fixed beat quota per job. It also keeps
// done/idle/ready flags, a saturating sequence counter and a sticky protocol-error flag.
// Only valid/ready pass through this block; the data buses are routed around it.
`timescale 1ns/1ps

module mmul_parallel_engine_seq #(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned N_OUT  = 1,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned JOB_W  = 16,
    parameter int unsigned DONE_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              test_mode_i,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [JOB_W-1:0]  n_jobs_i,
    input  logic [CNT_W-1:0]  in_beats_i,
    input  logic [CNT_W-1:0]  out_beats_i,
    input  logic [N_IN-1:0]   in_valid_i,
    output logic [N_IN-1:0]   in_ready_o,
    output logic [N_IN-1:0]   k_in_valid_o,
    input  logic [N_IN-1:0]   k_in_ready_i,
    input  logic [N_OUT-1:0]  k_out_valid_i,
    output logic [N_OUT-1:0]  k_out_ready_o,
    output logic [N_OUT-1:0]  out_valid_o,
    input  logic [N_OUT-1:0]  out_ready_i,
    output logic              k_start_o,
    output logic              k_clear_o,
    input  logic              k_done_i,
    output logic              done_o,
    output logic              idle_o,
    output logic              ready_o,
    output logic [JOB_W-1:0]  job_cnt_o,
    output logic [DONE_W-1:0] done_cnt_o,
    output logic              err_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_NEXT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]                       state;
    logic [JOB_W-1:0]                 n_jobs_q;
    logic [JOB_W-1:0]                 job_cnt;
    logic [DONE_W-1:0]                done_cnt;
    logic [CNT_W-1:0]                 in_beats_q;
    logic [CNT_W-1:0]                 out_beats_q;
    logic [N_IN-1:0][CNT_W-1:0]       in_cnt;
    logic [N_IN-1:0][CNT_W-1:0]       in_cnt_nxt;
    logic [N_OUT-1:0][CNT_W-1:0]      out_cnt;
    logic [N_OUT-1:0][CNT_W-1:0]      out_cnt_nxt;
    logic [N_IN-1:0]                  in_open;
    logic [N_IN-1:0]                  in_fire;
    logic [N_OUT-1:0]                 out_open;
    logic [N_OUT-1:0]                 out_fire;
    logic                             all_met;
    logic                             last_job;
    logic                             kdone_q;
    logic                             err_q;
    logic                             ready_q;
    logic                             unused_test_mode;

    assign unused_test_mode = test_mode_i;

    // Per-channel gates, beat fires and post-edge counter values. The quota check uses
    // the post-edge counts so a final beat and k_done in the same cycle still count
    // as a clean completion.
    always_comb begin
        all_met = 1'b1;
        for (int unsigned i = 0; i < N_IN; i++) begin
            in_open[i]    = (state == S_RUN) && (in_cnt[i] < in_beats_q);
            in_fire[i]    = in_valid_i[i] & k_in_ready_i[i] & in_open[i];
            in_cnt_nxt[i] = in_cnt[i] + CNT_W'(in_fire[i]);
            if (in_cnt_nxt[i] < in_beats_q) begin
                all_met = 1'b0;
            end
        end
        for (int unsigned o = 0; o < N_OUT; o++) begin
            out_open[o]    = (state == S_RUN) && (out_cnt[o] < out_beats_q);
            out_fire[o]    = k_out_valid_i[o] & out_ready_i[o] & out_open[o];
            out_cnt_nxt[o] = out_cnt[o] + CNT_W'(out_fire[o]);
            if (out_cnt_nxt[o] < out_beats_q) begin
                all_met = 1'b0;
            end
        end
    end

    // Whether the job being retired in NEXT is the last of the sequence.
    always_comb begin
        last_job = ({1'b0, job_cnt} + {{JOB_W{1'b0}}, 1'b1}) >= {1'b0, n_jobs_q};
    end

    assign k_in_valid_o  = in_valid_i & in_open;
    assign in_ready_o    = k_in_ready_i & in_open;
    assign out_valid_o   = k_out_valid_i & out_open;
    assign k_out_ready_o = out_ready_i & out_open;

    assign k_start_o  = (state == S_LAUNCH);
    assign k_clear_o  = clear_i;
    assign done_o     = (state == S_DONE);
    assign idle_o     = (state == S_IDLE);
    assign ready_o    = ready_q;
    assign job_cnt_o  = job_cnt;
    assign done_cnt_o = done_cnt;
    assign err_o      = err_q;

    // Sequencer FSM together with quota counters, job/sequence counters and the error flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            n_jobs_q    <= '0;
            in_beats_q  <= '0;
            out_beats_q <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            kdone_q     <= 1'b0;
            job_cnt     <= '0;
            done_cnt    <= '0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            ready_q <= (state == S_IDLE);
            if (clear_i) begin
                state    <= S_IDLE;
                in_cnt   <= '0;
                out_cnt  <= '0;
                kdone_q  <= 1'b0;
                job_cnt  <= '0;
                done_cnt <= '0;
                err_q    <= 1'b0;
            end else begin
                if (k_done_i && (state != S_RUN)) begin
                    err_q <= 1'b1;
                end
                case (state)
                    S_IDLE: begin
                        if (start_i) begin
                            n_jobs_q    <= n_jobs_i;
                            in_beats_q  <= in_beats_i;
                            out_beats_q <= out_beats_i;
                            if (n_jobs_i == '0) begin
                                state <= S_DONE;
                            end else begin
                                job_cnt <= '0;
                                state   <= S_LAUNCH;
                            end
                        end
                    end
                    S_LAUNCH: begin
                        in_cnt  <= '0;
                        out_cnt <= '0;
                        kdone_q <= 1'b0;
                        state   <= S_RUN;
                    end
                    S_RUN: begin
                        in_cnt  <= in_cnt_nxt;
                        out_cnt <= out_cnt_nxt;
                        if (k_done_i) begin
                            kdone_q <= 1'b1;
                        end
                        // Kernel finishing early with quotas unmet aborts the job.
                        if (k_done_i && !all_met) begin
                            err_q <= 1'b1;
                            state <= S_NEXT;
                        end else if ((k_done_i || kdone_q) && all_met) begin
                            state <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        job_cnt <= job_cnt + JOB_W'(1);
                        state   <= last_job ? S_DONE : S_LAUNCH;
                    end
                    S_DONE: begin
                        if (done_cnt != '1) begin
                            done_cnt <= done_cnt + DONE_W'(1);
                        end
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mmul_parallel_engine_seq.sv
// Testbench for mmul_parallel_engine_seq: a reactive kernel model drives the kernel
// side, and a scoreboard holds expected per-job beats and per-sequence results.
`timescale 1ns/1ps

module tb_mmul_parallel_engine_seq;

    localparam int N_IN   = 2;
    localparam int N_OUT  = 1;
    localparam int CNT_W  = 16;
    localparam int JOB_W  = 16;
    localparam int DONE_W = 2;
    localparam int DCNT_MAX = (1 << DONE_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              test_mode;
    logic              clear;
    logic              start;
    logic [JOB_W-1:0]  n_jobs;
    logic [CNT_W-1:0]  in_beats;
    logic [CNT_W-1:0]  out_beats;
    logic [N_IN-1:0]   in_valid;
    logic [N_IN-1:0]   in_ready;
    logic [N_IN-1:0]   k_in_valid;
    logic [N_IN-1:0]   k_in_ready;
    logic [N_OUT-1:0]  k_out_valid;
    logic [N_OUT-1:0]  k_out_ready;
    logic [N_OUT-1:0]  out_valid;
    logic [N_OUT-1:0]  out_ready;
    logic              k_start;
    logic              k_clear;
    logic              k_done;
    logic              done;
    logic              idle;
    logic              ready;
    logic [JOB_W-1:0]  job_cnt;
    logic [DONE_W-1:0] done_cnt;
    logic              err;

    always #5 clk = ~clk;

    mmul_parallel_engine_seq #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .CNT_W  (CNT_W),
        .JOB_W  (JOB_W),
        .DONE_W (DONE_W)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .test_mode_i   (test_mode),
        .clear_i       (clear),
        .start_i       (start),
        .n_jobs_i      (n_jobs),
        .in_beats_i    (in_beats),
        .out_beats_i   (out_beats),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .k_in_valid_o  (k_in_valid),
        .k_in_ready_i  (k_in_ready),
        .k_out_valid_i (k_out_valid),
        .k_out_ready_o (k_out_ready),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .k_start_o     (k_start),
        .k_clear_o     (k_clear),
        .k_done_i      (k_done),
        .done_o        (done),
        .idle_o        (idle),
        .ready_o       (ready),
        .job_cnt_o     (job_cnt),
        .done_cnt_o    (done_cnt),
        .err_o         (err)
    );

    typedef struct { int in0; int in1; int out; } job_t;
    typedef struct { int kstarts; int jobs; bit chk_job; int err; } seq_t;

    job_t exp_job_q[$];
    seq_t exp_seq_q[$];

    int vectors     = 0;
    int miscompares = 0;

    // Kernel-model configuration, written by the stimulus process.
    int cfg_in      = 4;
    int kout_limit  = 2;
    int kdone_after = 2;

    // Monitor state, owned by the kernel/monitor process.
    int kin [N_IN];
    int kout         = 0;
    int seq_kstarts  = 0;
    int seq_done_seen = 0;
    int exp_dcnt     = 0;
    bit job_active   = 1'b0;
    bit pend_done    = 1'b0;
    bit dcnt_pending = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic close_job();
        job_t e;
        if (exp_job_q.size() == 0) begin
            check("job_q_underflow", 64'd1, 64'd0);
        end else begin
            e = exp_job_q.pop_front();
            check("job_in0_beats", kin[0], e.in0);
            check("job_in1_beats", kin[1], e.in1);
            check("job_out_beats", kout, e.out);
        end
    endtask

    task automatic close_seq();
        seq_t s;
        if (exp_seq_q.size() == 0) begin
            check("seq_q_underflow", 64'd1, 64'd0);
        end else begin
            s = exp_seq_q.pop_front();
            check("seq_kstarts", seq_kstarts, s.kstarts);
            if (s.chk_job) check("seq_job_cnt", job_cnt, s.jobs);
            check("seq_err", err, s.err);
        end
    endtask

    // Reactive kernel plus monitor: drives just after negedge, samples 3 ns later.
    initial begin : kernel_model
        k_done      = 1'b0;
        k_out_valid = '0;
        for (int i = 0; i < N_IN; i++) kin[i] = 0;
        forever begin
            @(negedge clk);
            k_done    = pend_done;
            pend_done = 1'b0;
            k_out_valid[0] = (kin[0] >= cfg_in) && (kin[1] >= cfg_in) && (kout < kout_limit);
            #3;
            if (!rst_n) begin
                job_active = 1'b0;
            end else if (k_clear) begin
                job_active   = 1'b0;
                seq_kstarts  = 0;
                exp_dcnt     = 0;
                dcnt_pending = 1'b0;
            end else begin
                if (dcnt_pending) begin
                    check("done_cnt", done_cnt, exp_dcnt);
                    check("idle_after_done", idle, 1);
                    dcnt_pending = 1'b0;
                end
                if (k_start) begin
                    if (job_active) close_job();
                    job_active = 1'b1;
                    for (int i = 0; i < N_IN; i++) kin[i] = 0;
                    kout = 0;
                    seq_kstarts++;
                end
                if (done) begin
                    if (job_active) close_job();
                    job_active = 1'b0;
                    close_seq();
                    seq_kstarts = 0;
                    if (exp_dcnt < DCNT_MAX) exp_dcnt++;
                    dcnt_pending = 1'b1;
                    seq_done_seen++;
                end
                if (job_active && (kin[0] >= cfg_in)) begin
                    check("in0_gate_closed", {in_ready[0], k_in_valid[0]}, 2'b00);
                end
                for (int i = 0; i < N_IN; i++) begin
                    if (k_in_valid[i] && k_in_ready[i]) kin[i]++;
                end
                if (k_out_valid[0] && k_out_ready[0]) begin
                    kout++;
                    if (kout == kdone_after) pend_done = 1'b1;
                end
            end
        end
    end

    task automatic wait_done(input int target, input int budget);
        for (int c = 0; c < budget && seq_done_seen < target; c++) @(negedge clk);
        check("seq_done_in_time", seq_done_seen >= target, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_seq(input int nj, input int ib, input int ob, input int limit,
                           input int at, input int exp_out, input int exp_err,
                           input bit chk_job);
        job_t j;
        seq_t s;
        int   target;
        cfg_in      = ib;
        kout_limit  = limit;
        kdone_after = at;
        n_jobs      = JOB_W'(nj);
        in_beats    = CNT_W'(ib);
        out_beats   = CNT_W'(ob);
        j.in0 = ib; j.in1 = ib; j.out = exp_out;
        for (int k = 0; k < nj; k++) exp_job_q.push_back(j);
        s.kstarts = nj; s.jobs = nj; s.chk_job = chk_job; s.err = exp_err;
        exp_seq_q.push_back(s);
        target = seq_done_seen + 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (nj == 0) begin
            check("zero_jobs_done_pulse", done, 1);
            check("zero_jobs_no_kstart", k_start, 0);
        end else begin
            check("kstart_after_start", k_start, 1);
        end
        wait_done(target, 400);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst_n      = 1'b0;
        test_mode  = 1'b0;
        clear      = 1'b0;
        start      = 1'b0;
        n_jobs     = '0;
        in_beats   = '0;
        out_beats  = '0;
        in_valid   = '1;
        k_in_ready = '1;
        out_ready  = '1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_idle", idle, 1);
        check("rst_ready", ready, 0);
        check("rst_kstart", k_start, 0);
        check("rst_done", done, 0);
        check("rst_job_cnt", job_cnt, 0);
        check("rst_done_cnt", done_cnt, 0);
        check("rst_err", err, 0);
        check("rst_gates", {in_ready, k_in_valid, out_valid, k_out_ready}, 6'b0);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", ready, 0);
        @(negedge clk);
        check("ready_after_release", ready, 1);
        check("idle_after_release", idle, 1);

        // Three clean jobs: 4/4/2 beats each
        run_seq(3, 4, 2, 2, 2, 2, 0, 1'b1);
        check("main_job_cnt_hold", job_cnt, 3);

        // Early k_done at out beat 1 of 2: both jobs abort, error sticks
        run_seq(2, 4, 2, 1, 1, 1, 1, 1'b1);
        repeat (4) @(negedge clk);
        check("err_sticky", err, 1);
        clear = 1'b1;
        #1;
        check("k_clear_follows", k_clear, 1);
        @(negedge clk);
        clear = 1'b0;
        check("clear_err", err, 0);
        check("clear_done_cnt", done_cnt, 0);
        check("clear_job_cnt", job_cnt, 0);

        // Zero-job sequences drive the 2-bit completion counter into saturation
        kout_limit = 2;
        for (int r = 0; r < 5; r++) run_seq(0, 4, 2, 2, 2, 0, 0, 1'b0);
        check("done_cnt_saturated", done_cnt, DCNT_MAX);

        // clear together with start in the middle of RUN
        cfg_in    = 4;
        n_jobs    = JOB_W'(3);
        in_beats  = CNT_W'(4);
        out_beats = CNT_W'(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun_gate_open", in_ready[0], 1);
        clear = 1'b1;
        start = 1'b1;
        #1;
        check("midrun_k_clear", k_clear, 1);
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        check("midrun_idle", idle, 1);
        check("midrun_done_cnt", done_cnt, 0);
        check("midrun_gates", {in_ready, k_in_valid}, 4'b0);
        @(negedge clk);
        check("midrun_start_ignored", k_start, 0);
        check("midrun_still_idle", idle, 1);

        repeat (2) @(negedge clk);
        check("job_q_drained", exp_job_q.size(), 0);
        check("seq_q_drained", exp_seq_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmul_parallel_engine_seq.md
# mmul_parallel_engine_seq

Parametrised job-sequencing engine for HWPE accelerators with N_IN sink and N_OUT source streams. It sits between the streamer and the kernel wrapper. It gates the stream handshakes per channel, launches the kernel for a programmed number of back-to-back jobs, and enforces a beat quota per channel per job. It reports done, idle and ready flags, a saturating completion counter and a sticky protocol-error flag. Data buses are routed around the block; only valid/ready pass through it.

## Interface
- N_IN, 2, number of input (sink) channels, ≥1
- N_OUT, 1, number of output (source) channels, ≥1
- CNT_W, 16, width of per-channel beat counters and quotas
- JOB_W, 16, width of job count and job counter
- DONE_W, 8, width of saturating completion counter

- clk_i  in  1  clock; all logic on rising edge
- rst_ni  in  1  reset; synchronous, active-low
- test_mode_i  in  1  no functional effect
- clear_i  in  1  synchronous soft clear
- start_i  in  1  launch a job sequence (sampled in IDLE only)
- n_jobs_i  in  JOB_W  jobs per sequence; sampled at start
- in_beats_i  in  CNT_W  beats per input channel per job; sampled at start
- out_beats_i  in  CNT_W  beats per output channel per job; sampled at start
- in_valid_i / in_ready_o  in/out  N_IN  upstream handshake
- k_in_valid_o / k_in_ready_i  out/in  N_IN  kernel-side input handshake
- k_out_valid_i / k_out_ready_o  in/out  N_OUT  kernel-side output handshake
- out_valid_o / out_ready_i  out/in  N_OUT  downstream handshake
- k_start_o, k_clear_o  out  1  kernel start pulse, kernel clear
- k_done_i  in  1  kernel end-of-job pulse
- done_o  out  1  1-cycle pulse at sequence end
- idle_o, ready_o  out  1  FSM in IDLE; registered ready
- job_cnt_o  out  JOB_W  jobs completed in current sequence
- done_cnt_o  out  DONE_W  sequences completed, saturating
- err_o  out  1  sticky protocol error

## Operation
- FSM states and transitions:
  - IDLE → LAUNCH on start_i.
  - LAUNCH → RUN.
  - RUN → NEXT when all quotas are met and k_done has been latched, or on error abort.
  - NEXT → LAUNCH if job_cnt+1 < n_jobs; otherwise NEXT → DONE.
  - DONE → IDLE.
- start_i with sampled n_jobs = 0: IDLE → DONE directly. No k_start_o is issued; done_o pulses.
- LAUNCH: k_start_o = 1. All beat counters and the k_done latch are zeroed.
- Channel gate: channel i is open iff state = RUN and in_cnt[i] < in_beats.
  - k_in_valid_o[i] = in_valid_i[i] & open.
  - in_ready_o[i] = k_in_ready_i[i] & open.
  - Output channels are gated the same way against out_beats.
- Beat counting: a beat counts on gated valid & ready. Counters stop at the quota and never wrap.
- Quota 0 for a channel: the channel is closed for the whole job and the quota counts as met.
- k_done_i in RUN is latched.
  - If any quota is still unmet in that cycle, err_o is set and the job aborts to NEXT on the next cycle.
  - k_done_i outside RUN sets err_o and is otherwise ignored.
- NEXT: job_cnt increments. job_cnt_o holds its value through DONE and IDLE until the next LAUNCH from IDLE.
- DONE: done_o = 1 and done_cnt increments, saturating at 2^DONE_W−1.
- clear_i: FSM → IDLE. All counters, latches and err_o are zeroed. k_clear_o = clear_i (combinational). clear_i beats start_i in the same cycle.
- start_i outside IDLE is ignored. Inputs are sampled only at IDLE→LAUNCH/DONE.

## Timing
- Reset values:
  - idle_o = 1.
  - ready_o = 0.
  - All other outputs = 0 (all gates closed, k_start_o = 0, err_o = 0, counters = 0).
- ready_o is registered: ready_o(t+1) = (state(t) = IDLE). It is 1 one cycle after reset release.
- start_i at cycle t → k_start_o at t+1 → gates open at t+2.
- Last qualifying event (final beat or k_done latch) at t → NEXT at t+1 → LAUNCH or DONE at t+2.
- done_o one cycle after NEXT; idle_o = 1 the following cycle.
- Minimum per-job overhead: 3 cycles (LAUNCH, NEXT, plus the completion cycle).
- Gating is combinational; there is no added latency on valid/ready.
- Reset is asserted mid-job: everything returns to reset values on the next edge.

## Test plan
- Reset, no stimulus: idle_o = 1, ready_o = 0 then 1 the next cycle. All gates closed and all counters 0.
- N_IN = 2, N_OUT = 1, n_jobs = 3, in_beats = 4, out_beats = 2, full-throughput streams, k_done_i after the final output beat of each job: 3 k_start_o pulses, each gate passes exactly 4/4/2 beats per job, done_o pulses once, job_cnt_o = 3, done_cnt_o = 1, err_o = 0.
- Upstream presents a 5th beat on in0 while in_beats = 4: in_ready_o[0] = 0 and k_in_valid_o[0] = 0 after beat 4.
- k_done_i when out beat count = 1 of 2: err_o = 1 and the job aborts. The sequence continues with the next job. err_o stays 1 until clear_i.
- n_jobs = 0: done_o pulses 1 cycle after start_i, no k_start_o. Then start_i asserted repeatedly with DONE_W = 2: done_cnt_o saturates at 3.
- clear_i mid-RUN together with start_i: FSM → IDLE, counters = 0, k_clear_o = 1 that cycle, start_i ignored.
